// File: rtl/load_store_unit.sv
// Load/store unit: issues RV32I loads and stores to data memory over req/ready and returns extended load data.
// Op encoding on id_ex_instr_type: 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW; any other value is not a memory op.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  id_ex_instr_type,
    input  logic [31:0] mem_addr,
    input  logic [31:0] store_data,
    input  logic [4:0]  id_ex_rd_addr,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic        lsu_stall,
    output logic        lsu_wb_valid,
    output logic [4:0]  lsu_wb_rd_addr,
    output logic [31:0] lsu_wb_data,
    output logic        lsu_misaligned,
    output logic        lsu_bus_error
);
    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LW  = 4'd3;
    localparam logic [3:0] OP_LBU = 4'd4;
    localparam logic [3:0] OP_LHU = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    localparam logic [31:0] TMO_LIMIT = 32'(TIMEOUT_CYCLES);
    localparam bit          TMO_EN    = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

    state_e      state;
    state_e      state_nxt;
    logic [31:0] tmo_cnt;
    logic [3:0]  op_q;
    logic [1:0]  lo_q;
    logic [4:0]  rd_q;

    logic        is_byte, is_half, is_word, is_store, is_mem, misaligned;
    logic        issue, mis_fire, ready_hit, tmo_hit;
    logic [3:0]  be_nxt;
    logic [31:0] wdata_nxt;
    logic [31:0] lane;
    logic [31:0] ld_data;

    always_comb begin
        is_byte    = id_ex_instr_type inside {OP_LB, OP_LBU, OP_SB};
        is_half    = id_ex_instr_type inside {OP_LH, OP_LHU, OP_SH};
        is_word    = id_ex_instr_type inside {OP_LW, OP_SW};
        is_store   = id_ex_instr_type inside {OP_SB, OP_SH, OP_SW};
        is_mem     = is_byte || is_half || is_word;
        misaligned = (is_half && mem_addr[0]) || (is_word && (mem_addr[1:0] != 2'b00));

        issue     = (state == IDLE) && is_mem && !misaligned;
        mis_fire  = (state == IDLE) && is_mem && misaligned;
        ready_hit = (state == REQ) && dmem_ready;
        // Ready in the same cycle as the limit still completes the access.
        tmo_hit   = (state == REQ) && !dmem_ready && TMO_EN && ((tmo_cnt + 32'd1) == TMO_LIMIT);
    end

    always_comb begin
        be_nxt    = 4'b1111;
        wdata_nxt = store_data;
        if (is_byte) begin
            be_nxt    = 4'b0001 << mem_addr[1:0];
            wdata_nxt = {4{store_data[7:0]}};
        end else if (is_half) begin
            be_nxt    = mem_addr[1] ? 4'b1100 : 4'b0011;
            wdata_nxt = {2{store_data[15:0]}};
        end
    end

    always_comb begin
        lane = dmem_rdata >> {lo_q, 3'b000};
        case (op_q)
            OP_LB:   ld_data = {{24{lane[7]}}, lane[7:0]};
            OP_LBU:  ld_data = {24'd0, lane[7:0]};
            OP_LH:   ld_data = {{16{lane[15]}}, lane[15:0]};
            OP_LHU:  ld_data = {16'd0, lane[15:0]};
            default: ld_data = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        lsu_stall = 1'b0;
        case (state)
            IDLE: begin
                lsu_stall = issue;
                if (issue) state_nxt = REQ;
            end
            REQ: begin
                lsu_stall = 1'b1;
                if (ready_hit || tmo_hit) state_nxt = DONE;
            end
            // The memory op is still presented here; it must not be re-issued.
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dmem_req       <= 1'b0;
            dmem_we        <= 1'b0;
            dmem_addr      <= 32'd0;
            dmem_be        <= 4'd0;
            dmem_wdata     <= 32'd0;
            lsu_wb_valid   <= 1'b0;
            lsu_wb_rd_addr <= 5'd0;
            lsu_wb_data    <= 32'd0;
            lsu_misaligned <= 1'b0;
            lsu_bus_error  <= 1'b0;
            tmo_cnt        <= 32'd0;
            op_q           <= 4'd0;
            lo_q           <= 2'd0;
            rd_q           <= 5'd0;
        end else begin
            lsu_wb_valid   <= 1'b0;
            lsu_misaligned <= mis_fire;
            lsu_bus_error  <= tmo_hit;
            if (issue) begin
                dmem_req   <= 1'b1;
                dmem_we    <= is_store;
                dmem_addr  <= {mem_addr[31:2], 2'b00};
                dmem_be    <= be_nxt;
                dmem_wdata <= wdata_nxt;
                op_q       <= id_ex_instr_type;
                lo_q       <= mem_addr[1:0];
                rd_q       <= id_ex_rd_addr;
            end
            if (state == REQ) begin
                if (ready_hit || tmo_hit) begin
                    dmem_req <= 1'b0;
                    tmo_cnt  <= 32'd0;
                end else begin
                    tmo_cnt <= tmo_cnt + 32'd1;
                end
                if (ready_hit && !dmem_we) begin
                    lsu_wb_data    <= ld_data;
                    lsu_wb_rd_addr <= rd_q;
                    lsu_wb_valid   <= (rd_q != 5'd0);
                end
            end
        end
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access block beside the execute stage. Consumes the execute stage's unbuffered ALU address and forwarded rs2 data for RV32I loads and stores.
- Runs a req/ready handshake to data memory and stalls the pipeline while an access is in flight.
- Delivers byte/half/word-extracted, sign- or zero-extended load data to writeback.
- Flags misaligned accesses and bus timeouts instead of issuing them.

Parameters:
TIMEOUT_CYCLES, 256, max cycles dmem_req may wait for dmem_ready before abort; 0 disables the timeout.

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
id_ex_instr_type  input  rv32i_instr_e  instruction in execute; LB/LH/LW/LBU/LHU/SB/SH/SW are memory ops, all others are ignored
mem_addr  input  32  byte address from execute ALU, combinational
store_data  input  32  forwarded rs2 value
id_ex_rd_addr  input  5  load destination register
dmem_req  output  1  request valid, held until dmem_ready
dmem_we  output  1  1 = store
dmem_addr  output  32  word address, {addr[31:2],2'b00}
dmem_be  output  4  byte lane enables
dmem_wdata  output  32  lane-replicated store data
dmem_rdata  input  32  read data, valid when dmem_ready && !dmem_we
dmem_ready  input  1  transaction completes this cycle
lsu_stall  output  1  freeze pipeline, combinational
lsu_wb_valid  output  1  one-cycle load writeback strobe
lsu_wb_rd_addr  output  5  load destination
lsu_wb_data  output  32  extended load result
lsu_misaligned  output  1  one-cycle misaligned-access pulse
lsu_bus_error  output  1  one-cycle timeout pulse

Behaviour:
- FSM states: IDLE, REQ, DONE.
- Reset: state=IDLE, timeout counter=0. All registered outputs are 0: dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, lsu_wb_valid, lsu_wb_rd_addr, lsu_wb_data, lsu_misaligned, lsu_bus_error.
- Reset mid-transaction: abandon the access. dmem_req is low from the cycle after the reset edge. No writeback, no error pulse.
- Misalignment rules:
  - LH, LHU, SH are misaligned when addr[0]=1.
  - LW, SW are misaligned when addr[1:0]!=0.
  - Byte ops are never misaligned.
- IDLE, aligned memory op present:
  - lsu_stall=1 this cycle.
  - On the edge, latch we, word address, be, wdata, rd, load type and addr[1:0]; go to REQ.
- IDLE, misaligned op present:
  - lsu_stall=0, no request.
  - Register lsu_misaligned=1 for exactly one cycle; no writeback.
- IDLE, non-memory op: lsu_stall=0; stay in IDLE.
- REQ:
  - dmem_req=1 and lsu_stall=1. Request fields stay stable until dmem_ready.
  - On dmem_ready: drop req, go to DONE. For loads, register the extracted data, lsu_wb_rd_addr=rd, and lsu_wb_valid=1 (only if rd!=0).
  - Timeout counter increments each REQ cycle without ready. When it reaches TIMEOUT_CYCLES (nonzero): drop req, pulse lsu_bus_error for one cycle, go to DONE with no writeback.
  - Counter clears on leaving REQ.
- DONE:
  - lsu_stall=0, so the pipeline advances past the memory op at the end of this cycle.
  - lsu_wb_valid / lsu_bus_error are visible this cycle only. Next state IDLE.
  - DONE never accepts a new op, which prevents re-issue of the still-present instruction.
- Latency: with dmem_ready in the first REQ cycle, the op is stalled for 2 cycles, and lsu_wb_valid appears in cycle 3 relative to the op's arrival at cycle 1. Each additional wait cycle adds 1.
- Byte enables (loads use the same lanes, with dmem_we=0):
  - Byte op: be = 4'b0001 << addr[1:0].
  - Half op: be = addr[1] ? 4'b1100 : 4'b0011.
  - Word op: be = 4'b1111.
- Store data:
  - SB: {4{store_data[7:0]}}.
  - SH: {2{store_data[15:0]}}.
  - SW: store_data.
- Load extraction (lane selected by latched addr[1:0]):
  - LB / LH sign-extend.
  - LBU / LHU zero-extend.
  - LW passes the full word.
- dmem_rdata is ignored for stores. Stores never assert lsu_wb_valid.

Test Plan:
- LW at 0x100, dmem_ready in first REQ cycle, rdata=0xDEADBEEF, rd=5 -> dmem_addr=0x100, be=1111, stall for 2 cycles; then wb_valid=1, rd=5, data=0xDEADBEEF for 1 cycle.
- LB at 0x103 and LBU at 0x103, rdata=0x80FF1234 -> data=0xFFFFFF80 and 0x00000080 respectively; be=1000.
- SH at 0x202, store_data=0x0000ABCD, ready after 3 wait cycles -> dmem_we=1, addr=0x200, be=1100, wdata=0xABCDABCD held stable 4 cycles; no wb_valid.
- LW at 0x101 -> no dmem_req, lsu_stall=0, lsu_misaligned pulses 1 cycle, no writeback. Repeat with LH at 0x101, and SB at 0x101 (SB must issue with be=0010).
- TIMEOUT_CYCLES=4, dmem_ready held low -> req high 4 cycles, then lsu_bus_error 1-cycle pulse, stall released, FSM back to IDLE; rst asserted in the 2nd REQ cycle of a separate access -> dmem_req low the next cycle, no pulses.
- LW with rd=0 followed back-to-back by SW -> no wb_valid for the load; the SW is issued only after DONE, exactly once each.
